// File: rtl/timer_scheduler_if.sv
// Request/grant bundle between requesters and the shared timer_scheduler.
// master drives requests and durations; slave is the scheduler.
interface timer_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] dur;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic                  tick;
  logic [WIDTH-1:0]      remaining;

  modport master (output req, dur, input grant, done, busy, tick, remaining);
  modport slave  (input req, dur, output grant, done, busy, tick, remaining);
endinterface

// File: rtl/timer_scheduler.sv
// Round-robin owner of one prescaled down-counting timer shared by NREQ requesters.
// Optional macro TIMER_SCHEDULER_ABORT_EN: owner dropping req during RUN aborts the run.
module timer_scheduler #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TICKDIV = 100_000
) (
  input logic              clk,
  input logic              reset,
  timer_scheduler_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKDIV - 1);
  localparam logic [IW-1:0] LAST_RST  = IW'(NREQ - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state;
  logic [NREQ-1:0]  r_grant;
  logic [NREQ-1:0]  r_done;
  logic             r_busy;
  logic             r_tick;
  logic [WIDTH-1:0] r_remaining;
  logic [PW-1:0]    r_presc;
  logic [IW-1:0]    r_last;

  logic [IW-1:0]    w_winner;
  logic             w_found;
  logic [WIDTH-1:0] w_dur_arr [NREQ];
  logic [WIDTH-1:0] w_win_dur;
  logic [PW-1:0]    w_presc_inc;

  for (genvar g = 0; g < NREQ; g++) begin : g_dur
    assign w_dur_arr[g] = bus.dur[g*WIDTH +: WIDTH];
  end

  assign w_win_dur   = w_dur_arr[w_winner];
  assign w_presc_inc = r_presc + PW'(1);

  // Round-robin search starting just after the previous owner, wrapping around.
  always_comb begin
    logic [IW-1:0] idx;
    logic          hit;
    w_winner = r_last;
    w_found  = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx      = IW'((int'(r_last) + i) % NREQ);
      hit      = bus.req[idx] & ~w_found;
      w_winner = hit ? idx : w_winner;
      w_found  = w_found | hit;
    end
  end

  // Scheduler FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_done      <= '0;
      r_busy      <= 1'b0;
      r_tick      <= 1'b0;
      r_remaining <= '0;
      r_presc     <= '0;
      r_last      <= LAST_RST;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done  <= '0;
          r_presc <= '0;
          if (w_found) begin
            r_state     <= S_RUN;
            r_grant     <= NREQ'(1) << w_winner;
            r_remaining <= w_win_dur;
            r_last      <= w_winner;
            r_busy      <= 1'b1;
            r_tick      <= (TICKDIV == 1) && (w_win_dur != '0);
          end else begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_tick  <= 1'b0;
          end
        end
        S_RUN: begin
`ifdef TIMER_SCHEDULER_ABORT_EN
          if (!bus.req[r_last]) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_busy      <= 1'b0;
            r_tick      <= 1'b0;
            r_remaining <= '0;
            r_presc     <= '0;
          end else
`endif
          if (r_remaining == '0) begin
            // Zero-length run: one RUN cycle, no tick.
            r_state <= S_DONE;
            r_done  <= r_grant;
            r_tick  <= 1'b0;
            r_presc <= '0;
          end else if (r_presc == PRESC_MAX) begin
            r_presc     <= '0;
            r_remaining <= r_remaining - WIDTH'(1);
            if (r_remaining == WIDTH'(1)) begin
              r_state <= S_DONE;
              r_done  <= r_grant;
              r_tick  <= 1'b0;
            end else begin
              r_tick <= (TICKDIV == 1);
            end
          end else begin
            r_presc <= w_presc_inc;
            r_tick  <= (w_presc_inc == PRESC_MAX);
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_grant     <= '0;
          r_done      <= '0;
          r_busy      <= 1'b0;
          r_tick      <= 1'b0;
          r_remaining <= '0;
          r_presc     <= '0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_grant     <= '0;
          r_done      <= '0;
          r_busy      <= 1'b0;
          r_tick      <= 1'b0;
          r_remaining <= '0;
          r_presc     <= '0;
        end
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.done      = r_done;
  assign bus.busy      = r_busy;
  assign bus.tick      = r_tick;
  assign bus.remaining = r_remaining;
endmodule

// File: doc/timer_scheduler.md
TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the timer.
REQ-002 Parameter WIDTH, default 8: width of each duration and of the remaining count.
REQ-003 Parameter TICKDIV, default 100_000: clk cycles per timer tick.
REQ-004 Port clk, input, 1: sole clock; all logic on its rising edge.
REQ-005 Port reset, input, 1: synchronous active-high reset.
REQ-006 Port req, input, NREQ: level request per requester.
REQ-007 Port dur, input, NREQ*WIDTH: requester i duration in ticks, bits [i*WIDTH +: WIDTH].
REQ-008 Port grant, output, NREQ: one-hot owner of the timer; all-zero when unowned.
REQ-009 Port done, output, NREQ: one-cycle completion pulse to the owner.
REQ-010 Port busy, output, 1: high whenever state is not IDLE.
REQ-011 Port tick, output, 1: one-cycle pulse on each prescaler wrap during RUN.
REQ-012 Port remaining, output, WIDTH: ticks left for the current owner.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 In IDLE with any req bit high, the block SHALL select one winner round-robin, searching from index last+1 upward with wrap-around.
REQ-015 On selection, the block SHALL apply all of the following at the next edge:
- grant = one-hot winner
- remaining = dur[winner]
- prescaler = 0
- last = winner
- state = RUN
REQ-016 Grant latency SHALL be exactly 1 cycle from req sampled high in IDLE.
REQ-017 dur is sampled only at selection; later changes to dur SHALL have no effect.
REQ-018 In RUN, the prescaler SHALL count 0..TICKDIV-1 and wrap to 0.
REQ-019 On each prescaler wrap, tick SHALL pulse high and remaining SHALL decrement by 1.
REQ-020 When remaining decrements from 1 to 0, the next state SHALL be DONE.
REQ-021 Grant-to-DONE time SHALL be exactly dur*TICKDIV cycles.
REQ-022 If the sampled dur is 0, RUN SHALL last 1 cycle with no tick, then go to DONE.
REQ-023 In DONE, the block SHALL:
- assert done[owner] for exactly that cycle
- keep grant asserted
- go to IDLE on the next edge, clearing grant
REQ-024 A requester holding req high through DONE SHALL be re-arbitrated in IDLE behind every other pending requester.
REQ-025 remaining SHALL never decrement below 0.
REQ-026 The prescaler SHALL be held at 0 outside RUN.
REQ-027 At most one grant bit and one done bit SHALL be high in any cycle, and the done bit SHALL equal the grant bit.
REQ-028 Requests arriving during RUN or DONE SHALL be queued only by their level; no edge is latched.

Reset
REQ-029 reset SHALL dominate all other inputs at the clock edge.
REQ-030 On reset, the block SHALL set:
- state = IDLE
- grant, done, busy, tick, remaining, prescaler = 0
- last = NREQ-1, so requester 0 wins first
REQ-031 Reset asserted during RUN or DONE SHALL abandon the owner with no done pulse.

Configuration
REQ-032 With macro TIMER_SCHEDULER_ABORT_EN defined, req[owner] sampled low in RUN SHALL return the FSM to IDLE at the next edge, with:
- grant = 0
- remaining = 0
- no done pulse
- last unchanged
REQ-033 Without TIMER_SCHEDULER_ABORT_EN, req in RUN SHALL be ignored and the run SHALL always complete through DONE.

Verification (TICKDIV=4, WIDTH=8, NREQ=4)
REQ-034 Single request: req=0001, dur0=3 at cycle 0 -> the bench SHALL check:
- grant=0001 at cycle 1
- tick at cycles 4, 8, 12
- remaining 3→2→1→0
- done=0001 at cycle 13
- grant=0 at cycle 14
REQ-035 Round-robin: req=1111 held, all dur=1 -> grants SHALL be 0001, 0010, 0100, 1000, 0001, each followed by its done pulse.
REQ-036 Zero duration: req=0100, dur2=0 -> the bench SHALL check:
- grant=0100 at cycle 1
- done=0100 at cycle 2
- tick never asserted
REQ-037 Reset at the cycle of the second tick of a dur=5 run -> next cycle SHALL show IDLE, grant=0, done never pulsed, and requester 0 wins the next arbitration.
REQ-038 Abort: owner drops req at cycle 6 of a dur=4 run.
- With TIMER_SCHEDULER_ABORT_EN: grant=0 at cycle 7, no done.
- Without it: done at cycle 17.
REQ-039 Mid-run dur change: dur0 changed from 2 to 9 during RUN -> done SHALL still arrive 8 cycles after grant.
